// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
//   Read end of the 8051 UART transmit path. Pops one byte at a time from the
//   TX FIFO read port and shifts it out on tx as an asynchronous frame:
//   start bit, DATA_WIDTH data bits LSB-first, optional parity bit, stop bit(s).
//   Optional feature macro: UART_TX_PARITY_EN (inserts an even/odd parity bit,
//   selected by parity_odd). Without it parity_odd is accepted and ignored.
//   fifo_rd_en is decoded from the registered FSM state and the FIFO status in
//   the IDLE cycle itself, so that the popped byte is on fifo_rd_data during
//   FETCH and the start bit follows two clocks after the pop strobe.
module uart_tx_serializer #(
   parameter int DATA_WIDTH  = 8,
   parameter int CLK_PER_BIT = 16,
   parameter int STOP_BITS   = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  tx_en,
   input  logic                  fifo_empty,
   output logic                  fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   input  logic                  parity_odd,
   output logic                  tx,
   output logic                  busy,
   output logic                  tx_done
);

   localparam int BAUD_W = $clog2(CLK_PER_BIT);
   localparam int BIT_W  = $clog2(DATA_WIDTH);

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_PER_BIT - 1);
   localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLK_PER_BIT - 2);
   localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1'b1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
   localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
   localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1'b1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_START  = 3'd2,
      ST_DATA   = 3'd3,
`ifdef UART_TX_PARITY_EN
      ST_PARITY = 3'd5,
`endif
      ST_STOP   = 3'd4
   } state_t;

`ifdef UART_TX_PARITY_EN
   // Even-parity reduction of a data word (1 when the number of ones is odd)
   function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] data);
      return ^data;
   endfunction
   logic                  par_r;
`else
   logic                  unused_parity_s;
   assign unused_parity_s = parity_odd;
`endif

   state_t                state_r;
   logic                  run_r;
   logic [DATA_WIDTH-1:0] shift_r;
   logic [BAUD_W-1:0]     baud_cnt_r;
   logic [BIT_W-1:0]      bit_cnt_r;
   logic                  tx_r;
   logic                  busy_r;
   logic                  tx_done_r;
   logic                  pop_s;

   // Pop only from IDLE, never while empty and never while held in reset
   assign pop_s      = (state_r == ST_IDLE) && run_r && tx_en && !fifo_empty;
   assign fifo_rd_en = pop_s;
   assign tx         = tx_r;
   assign busy       = busy_r;
   assign tx_done    = tx_done_r;

   // Run flag: keeps the pop strobe low while rst_n is asserted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_r <= 1'b0;
      end else begin
         run_r <= 1'b1;
      end
   end

   // Frame sequencer: state, baud/bit counters, shift register and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         shift_r    <= '0;
         baud_cnt_r <= '0;
         bit_cnt_r  <= '0;
         tx_r       <= 1'b1;
         busy_r     <= 1'b0;
         tx_done_r  <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_r      <= 1'b0;
`endif
      end else begin
         tx_done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               tx_r       <= 1'b1;
               baud_cnt_r <= '0;
               bit_cnt_r  <= '0;
               if (pop_s) begin
                  state_r <= ST_FETCH;
                  busy_r  <= 1'b1;
               end else begin
                  busy_r  <= 1'b0;
               end
            end
            ST_FETCH: begin
               shift_r    <= fifo_rd_data;
`ifdef UART_TX_PARITY_EN
               par_r      <= calc_parity(fifo_rd_data);
`endif
               baud_cnt_r <= '0;
               bit_cnt_r  <= '0;
               tx_r       <= 1'b0;
               state_r    <= ST_START;
            end
            ST_START: begin
               if (baud_cnt_r == BAUD_LAST) begin
                  baud_cnt_r <= '0;
                  tx_r       <= shift_r[0];
                  state_r    <= ST_DATA;
               end else begin
                  baud_cnt_r <= baud_cnt_r + BAUD_ONE;
               end
            end
            ST_DATA: begin
               if (baud_cnt_r == BAUD_LAST) begin
                  baud_cnt_r <= '0;
                  if (bit_cnt_r == BIT_LAST) begin
                     bit_cnt_r <= '0;
`ifdef UART_TX_PARITY_EN
                     tx_r      <= par_r ^ parity_odd;
                     state_r   <= ST_PARITY;
`else
                     tx_r      <= 1'b1;
                     state_r   <= ST_STOP;
`endif
                  end else begin
                     bit_cnt_r <= bit_cnt_r + BIT_ONE;
                     shift_r   <= {1'b0, shift_r[DATA_WIDTH-1:1]};
                     tx_r      <= shift_r[1];
                  end
               end else begin
                  baud_cnt_r <= baud_cnt_r + BAUD_ONE;
               end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
               if (baud_cnt_r == BAUD_LAST) begin
                  baud_cnt_r <= '0;
                  tx_r       <= 1'b1;
                  state_r    <= ST_STOP;
               end else begin
                  baud_cnt_r <= baud_cnt_r + BAUD_ONE;
               end
            end
`endif
            ST_STOP: begin
               tx_r <= 1'b1;
               // Flag the upcoming cycle when it is the last one of the final stop bit
               tx_done_r <= (baud_cnt_r == BAUD_PRE) && (bit_cnt_r == STOP_LAST);
               if (baud_cnt_r == BAUD_LAST) begin
                  baud_cnt_r <= '0;
                  if (bit_cnt_r == STOP_LAST) begin
                     bit_cnt_r <= '0;
                     busy_r    <= 1'b0;
                     state_r   <= ST_IDLE;
                  end else begin
                     bit_cnt_r <= bit_cnt_r + BIT_ONE;
                  end
               end else begin
                  baud_cnt_r <= baud_cnt_r + BAUD_ONE;
               end
            end
            default: begin
               state_r    <= ST_IDLE;
               baud_cnt_r <= '0;
               bit_cnt_r  <= '0;
               tx_r       <= 1'b1;
               busy_r     <= 1'b0;
            end
         endcase
      end
   end

endmodule
